// File: rtl/fifo_sched_pkg.sv
// Shared types and default constants for the FIFO read/write scheduler.
// Latency: none (declarations only).
// Backpressure: not applicable.
package fifo_sched_pkg;

    localparam int DEF_DIV   = 8000000;
    localparam int DEF_UW    = 4;
    localparam int DEF_HI_WM = 12;

    typedef enum logic [1:0] {
        STREAM = 2'd0,
        FILL   = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    // FILL is the only legal state that holds reads off.
    function automatic logic reads_allowed(input logic [1:0] s);
        return (s == STREAM) || (s == DRAIN);
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: free-running 0..DIV-1 counter, tick high while count == DIV-1.
// Latency: tick is combinational from the count register; first tick DIV cycles after reset.
// Backpressure: none, runs every cycle; reset discards any partial period.
module tick_gen
    import fifo_sched_pkg::*;
#(
    parameter int DIV = DEF_DIV
) (
    input  logic CLK,
    input  logic RST,
    output logic tick
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    // Period counter, wraps after the last count of the period.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/fifo_sched.sv
// Tick-paced FIFO write/read scheduler with STREAM / FILL / DRAIN read policy.
// Latency: wrreq/rdreq are registered, asserted the cycle after a tick; state updates every cycle.
// Backpressure: full suppresses writes, empty suppresses reads; optional FIFO_SCHED_STATS_EN adds drop/starve counters.
module fifo_sched
    import fifo_sched_pkg::*;
#(
    parameter int DIV   = DEF_DIV,
    parameter int UW    = DEF_UW,
    parameter int HI_WM = DEF_HI_WM
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          ENgen,
    input  logic          ENraf,
    input  logic [UW-1:0] usedw,
    input  logic          full,
    input  logic          empty,
    output logic          wrreq,
    output logic          rdreq,
    output logic          tick,
    output logic [1:0]    state
`ifdef FIFO_SCHED_STATS_EN
    ,
    output logic [15:0]   drop_cnt,
    output logic [15:0]   starve_cnt
`endif
);

    // Watermark at the full usedw width; no wrap correction, full covers the wrapped case.
    localparam logic [UW-1:0] HI_LVL = UW'(HI_WM);

    logic       tick_i;
    logic [1:0] state_q;
    logic [1:0] state_d;
    logic       read_ok;

    tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .CLK  (CLK),
        .RST  (RST),
        .tick (tick_i)
    );

    assign tick  = tick_i;
    assign state = state_q;

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= STREAM;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: ENraf low forces STREAM ahead of any other transition; 2'd3 recovers to STREAM.
    always_comb begin
        state_d = state_q;
        if (!ENraf) begin
            state_d = STREAM;
        end else begin
            case (state_q)
                STREAM:  state_d = FILL;
                FILL:    if ((usedw >= HI_LVL) || full) state_d = DRAIN;
                DRAIN:   if (empty) state_d = FILL;
                default: state_d = STREAM;
            endcase
        end
    end

    // Output decode: read permission comes from the current (pre-transition) state.
    always_comb begin
        read_ok = reads_allowed(state_q);
    end

    // Strobes: one-cycle pulses following a tick, from flags sampled in the tick cycle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wrreq <= 1'b0;
            rdreq <= 1'b0;
        end else begin
            wrreq <= tick_i & ENgen & ~full;
            rdreq <= tick_i & ~empty & read_ok;
        end
    end

`ifdef FIFO_SCHED_STATS_EN
    logic [15:0] drop_q;
    logic [15:0] starve_q;

    // Saturating counters of refused writes and of read slots that found the FIFO empty.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            drop_q   <= 16'd0;
            starve_q <= 16'd0;
        end else begin
            if (tick_i && ENgen && full && (drop_q != 16'hFFFF)) begin
                drop_q <= drop_q + 16'd1;
            end
            if (tick_i && read_ok && empty && (starve_q != 16'hFFFF)) begin
                starve_q <= starve_q + 16'd1;
            end
        end
    end

    assign drop_cnt   = drop_q;
    assign starve_cnt = starve_q;
`endif

endmodule

// File: doc/fifo_sched.md
FIFO_SCHED -- requirements
Module: fifo_sched

Interface
REQ-001 Parameter DIV, 8000000, tick period in CLK cycles; legal range >= 4.
REQ-002 Parameter UW, 4, width of the FIFO usedw input.
REQ-003 Parameter HI_WM, 12, usedw level at which FILL hands over to DRAIN; legal range 1..2^UW-1.
REQ-004 Port CLK  in  1  the single clock; all logic on posedge.
REQ-005 Port RST  in  1  reset, asynchronous and active-high.
REQ-006 Port ENgen  in  1  generator enable; writes are requested only while it is high.
REQ-007 Port ENraf  in  1  read-after-fill mode select; 1 selects FILL/DRAIN, 0 selects STREAM.
REQ-008 Port usedw  in  UW  FIFO occupancy.
REQ-009 Port full  in  1  FIFO full flag.
REQ-010 Port empty  in  1  FIFO empty flag.
REQ-011 Port wrreq  out  1  FIFO write strobe, one-cycle pulse.
REQ-012 Port rdreq  out  1  FIFO read strobe, one-cycle pulse.
REQ-013 Port tick  out  1  prescaler pulse, one cycle per period.
REQ-014 Port state  out  2  current scheduler state encoding.

Function
REQ-015 Prescaler: counter runs 0..DIV-1 and wraps to 0; tick is high exactly in the cycle where count == DIV-1.
REQ-016 wrreq is a registered output: it is high in the cycle after a tick, and only if ENgen=1 and full=0 were sampled in the tick cycle.
REQ-017 rdreq is a registered output: it is high in the cycle after a tick, and only if empty=0 was sampled in the tick cycle and the state permits reads.
REQ-018 wrreq and rdreq may be high in the same cycle; there is no priority between them.
REQ-019 No strobe is issued outside the cycle following a tick, so at most one write and one read occur per period.
REQ-020 State STREAM (2'd0): reads are permitted. Transition to FILL when ENraf=1.
REQ-021 State FILL (2'd1): reads are blocked. Transition to DRAIN when usedw >= HI_WM or full=1; transition to STREAM when ENraf=0.
REQ-022 State DRAIN (2'd2): reads are permitted. Transition to FILL when empty=1; transition to STREAM when ENraf=0.
REQ-023 Encoding 2'd3 is illegal and recovers to STREAM on the next cycle.
REQ-024 State is evaluated every CLK cycle, not only on ticks. An ENraf=0 transition takes precedence over every other transition.
REQ-025 If a state change and a tick fall in the same cycle, the read decision uses the state before the change.
REQ-026 usedw is compared unsigned at its full UW width; the block applies no wrap correction (full is authoritative).

Reset
REQ-027 RST=1 asynchronously forces: prescaler count to 0, state to STREAM, wrreq/rdreq/tick to 0, and the statistics counters to 0.
REQ-028 After RST deasserts, the first tick occurs exactly DIV cycles later. A reset asserted mid-period discards the partial period.
REQ-029 Any pending strobe is cancelled by reset, so no strobe is issued in the cycle following reset release.

Configuration
REQ-030 Macro FIFO_SCHED_STATS_EN present: output ports drop_cnt[15:0] and starve_cnt[15:0] exist.
REQ-031 drop_cnt increments on each tick where ENgen=1 and full=1.
REQ-032 starve_cnt increments on each tick where reads are permitted and empty=1.
REQ-033 Both counters saturate at 16'hFFFF.
REQ-034 Macro absent: these ports and their logic do not exist, and all other behaviour is identical.

Structure
REQ-035 Package fifo_sched_pkg holds the state enum (STREAM, FILL, DRAIN) and the default constants for DIV, UW and HI_WM.
REQ-036 Sub-module tick_gen (parameter DIV; ports CLK, RST, tick) implements the prescaler; fifo_sched instantiates it once.

Verification
REQ-037 Bench parameters: DIV=8, UW=4, HI_WM=12, with a 16-deep FIFO model.
REQ-038 Scenario: RST pulse, then ENgen=1, ENraf=0 -> tick at cycles 8, 16, ...; wrreq at cycles 9, 17, ...; first rdreq at cycle 17; usedw holds at 1.
REQ-039 Scenario: ENraf=1, ENgen=1 from empty -> no rdreq until usedw=12; state goes 1->2; rdreq then follows each tick; state returns to 1 when empty=1.
REQ-040 Scenario: ENgen=1 with ENraf held 1 and reads blocked until full -> wrreq stops at usedw=15 plus full; with FIFO_SCHED_STATS_EN, drop_cnt increments by 1 per later tick.
REQ-041 Scenario: drop ENraf to 0 while in DRAIN, in the same cycle as a tick -> state=0 next cycle, and rdreq still follows that tick.
REQ-042 Scenario: assert RST at prescaler count 5 -> all outputs 0 immediately; after release, the next tick comes 8 cycles later.
REQ-043 Scenario: force state to 2'd3 -> state=0 on the next cycle, with no spurious strobes.
